// File: rtl/filtr_peak_detector.sv
// filtr_peak_detector
// Tracks the peak magnitude of the filtered sample stream over a programmable
// window of samples. At the end of each window it makes a bit decision with a
// two-threshold hysteresis comparator and strobes the result to the decoder.
module filtr_peak_detector #(
  parameter int unsigned N      = 40,
  parameter int unsigned THR_HI = 1000,
  parameter int unsigned THR_LO = 500
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               i_valid,
  input  logic signed [31:0] i_signal,
  input  logic               enabel,
  input  logic [2:0]         address,
  input  logic [31:0]        data,
  output logic               o_valid,
  output logic               o_bit,
  output logic [31:0]        o_peak,
  output logic               o_busy
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  localparam logic [CNT_W-1:0]  LEN_RST    = CNT_W'(N);
  localparam logic [DATA_W-1:0] THR_HI_RST = DATA_W'(THR_HI);
  localparam logic [DATA_W-1:0] THR_LO_RST = DATA_W'(THR_LO);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [DATA_W-1:0]  r_thr_hi;
  logic [DATA_W-1:0]  r_thr_lo;
  logic [CNT_W-1:0]   r_len_cfg;
  logic [CNT_W-1:0]   r_len_act;
  logic [CNT_W-1:0]   r_count;
  logic [DATA_W-1:0]  r_peak;

  logic [CNT_W-1:0]   w_len_win;
  logic               w_vld_p0;
  logic               w_last_p0;
  logic [DATA_W-1:0]  w_mag_p0;
  logic [DATA_W-1:0]  w_peak_p0;
  logic               w_bit_p0;

  // Absolute value with saturation: the most negative input has no positive
  // twin in 32 bits, so it clamps to the largest positive magnitude.
  function automatic logic [DATA_W-1:0] f_mag(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] neg;
    neg = -x;
    if (!x[DATA_W-1]) return $unsigned(x);
    if (neg[DATA_W-1]) return {1'b0, {(DATA_W-1){1'b1}}};
    return $unsigned(neg);
  endfunction

  // Hysteresis decision; the upper test wins when the thresholds cross.
  function automatic logic f_decide(input logic [DATA_W-1:0] p,
                                    input logic [DATA_W-1:0] hi,
                                    input logic [DATA_W-1:0] lo,
                                    input logic              held);
    if (p >= hi) return 1'b1;
    if (p < lo)  return 1'b0;
    return held;
  endfunction

  // Control state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: arm on start, abandon the window as soon as start falls
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_ACC;
      S_ACC:   if (!start) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---- stage p0: incoming sample, combinational peak and decision ----
  // A fresh window (count 0) uses the configured length directly, so a length
  // of 1 decides on the very first sample.
  assign w_len_win = (r_count == '0) ? r_len_cfg : r_len_act;
  assign w_vld_p0  = (r_state == S_ACC) && start && i_valid;
  assign w_last_p0 = w_vld_p0 && (r_count == (w_len_win - CNT_W'(1)));
  assign w_mag_p0  = f_mag(i_signal);
  assign w_peak_p0 = (w_mag_p0 > r_peak) ? w_mag_p0 : r_peak;
  assign w_bit_p0  = f_decide(w_peak_p0, r_thr_hi, r_thr_lo, o_bit);

  // Register file writes; a zero window length is rejected
  always_ff @(posedge clk) begin
    if (reset) begin
      r_thr_hi  <= THR_HI_RST;
      r_thr_lo  <= THR_LO_RST;
      r_len_cfg <= LEN_RST;
    end else if (enabel) begin
      case (address)
        3'd0: r_thr_hi <= data;
        3'd1: r_thr_lo <= data;
        3'd2: if (data[CNT_W-1:0] != '0) r_len_cfg <= data[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  // ---- stage p1: window accumulation and registered results ----
  // Window accumulation, decision capture and the one-cycle result strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_peak    <= '0;
      r_len_act <= LEN_RST;
      o_valid   <= 1'b0;
      o_bit     <= 1'b0;
      o_peak    <= '0;
      o_busy    <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if ((r_state != S_ACC) || !start) begin
        r_count <= '0;
        r_peak  <= '0;
        o_busy  <= 1'b0;
      end else if (w_vld_p0) begin
        if (r_count == '0) r_len_act <= r_len_cfg;
        if (w_last_p0) begin
          r_count <= '0;
          r_peak  <= '0;
          o_busy  <= 1'b0;
          o_peak  <= w_peak_p0;
          o_bit   <= w_bit_p0;
          o_valid <= 1'b1;
        end else begin
          r_count <= r_count + CNT_W'(1);
          r_peak  <= w_peak_p0;
          o_busy  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_filtr_peak_detector.sv
// Self-checking bench for filtr_peak_detector: directed scenarios plus a
// randomized run, all compared against a window-queue reference model.
module tb_filtr_peak_detector;

  localparam int unsigned P_N  = 4;
  localparam int unsigned P_HI = 1000;
  localparam int unsigned P_LO = 500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset    = 1'b1;
  logic               start    = 1'b0;
  logic               i_valid  = 1'b0;
  logic signed [31:0] i_signal = '0;
  logic               enabel   = 1'b0;
  logic [2:0]         address  = '0;
  logic [31:0]        data     = '0;
  logic               o_valid;
  logic               o_bit;
  logic [31:0]        o_peak;
  logic               o_busy;

  int n_checks = 0;
  int n_fails  = 0;

  // reference model state
  longint unsigned m_thr_hi, m_thr_lo;
  int              m_len_cfg, m_win_len;
  bit              m_active;
  longint unsigned m_win[$];
  bit              exp_valid, exp_bit, exp_busy;
  logic [31:0]     exp_peak;

  filtr_peak_detector #(.N(P_N), .THR_HI(P_HI), .THR_LO(P_LO)) dut (
    .clk(clk), .reset(reset), .start(start), .i_valid(i_valid),
    .i_signal(i_signal), .enabel(enabel), .address(address), .data(data),
    .o_valid(o_valid), .o_bit(o_bit), .o_peak(o_peak), .o_busy(o_busy)
  );

  function automatic longint unsigned mag(input logic signed [31:0] x);
    longint v;
    v = x;
    if (v < 0) v = -v;
    if (v > 64'd2147483647) v = 2147483647;
    return v;
  endfunction

  // Model advance for one clock edge, using the inputs presented at that edge
  task automatic model_update();
    longint unsigned p;
    if (reset) begin
      m_thr_hi = P_HI; m_thr_lo = P_LO; m_len_cfg = P_N; m_win_len = P_N;
      m_active = 0; m_win.delete();
      exp_valid = 0; exp_bit = 0; exp_busy = 0; exp_peak = '0;
      return;
    end
    exp_valid = 0;
    if (!m_active) begin
      m_win.delete();
      m_active = start;
    end else if (!start) begin
      m_win.delete();
      m_active = 0;
    end else if (i_valid) begin
      if (m_win.size() == 0) m_win_len = m_len_cfg;
      m_win.push_back(mag(i_signal));
      if (m_win.size() == m_win_len) begin
        p = 0;
        foreach (m_win[k]) if (m_win[k] > p) p = m_win[k];
        if (p >= m_thr_hi)     exp_bit = 1;
        else if (p < m_thr_lo) exp_bit = 0;
        exp_peak  = p[31:0];
        exp_valid = 1;
        m_win.delete();
      end
    end
    if (enabel) begin
      case (address)
        3'd0: m_thr_hi = data;
        3'd1: m_thr_lo = data;
        3'd2: if (data[15:0] != 0) m_len_cfg = data[15:0];
        default: ;
      endcase
    end
    exp_busy = (m_win.size() != 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic send(input logic signed [31:0] x);
    i_valid = 1'b1; i_signal = x;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
    enabel = 1'b1; address = a; data = d;
    tick();
    enabel = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; i_valid = 1'b0; enabel = 1'b0;
    tick(); tick();
    n_checks++; if (o_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid got=%0b want=0", o_valid); end
    n_checks++; if (o_busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy got=%0b want=0", o_busy); end
    n_checks++; if (o_bit !== 1'b0) begin n_fails++; $display("FAIL reset_bit got=%0b want=0", o_bit); end
    n_checks++; if (o_peak !== 32'd0) begin n_fails++; $display("FAIL reset_peak got=%0d want=0", o_peak); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic signed [31:0] s [12] = '{10, -1200, 300, 5, 600, -700, 100, 0, 100, 200, -300, 400};
    logic [31:0] pk [3] = '{32'd1200, 32'd700, 32'd400};
    logic        bt [3] = '{1'b1, 1'b1, 1'b0};
    start = 1'b1;
    tick();
    for (int k = 0; k < 12; k++) begin
      send(s[k]);
      n_checks++;
      if ({o_valid, o_busy, o_bit, o_peak} !== {exp_valid, exp_busy, exp_bit, exp_peak}) begin
        n_fails++;
        $display("FAIL basic_model k=%0d got v=%0b busy=%0b bit=%0b peak=%0d want v=%0b busy=%0b bit=%0b peak=%0d",
                 k, o_valid, o_busy, o_bit, o_peak, exp_valid, exp_busy, exp_bit, exp_peak);
      end
      if (k % 4 == 3) begin
        n_checks++;
        if ({o_valid, o_peak, o_bit} !== {1'b1, pk[k/4], bt[k/4]}) begin
          n_fails++;
          $display("FAIL basic_window w=%0d got v=%0b peak=%0d bit=%0b want v=1 peak=%0d bit=%0b",
                   k/4, o_valid, o_peak, o_bit, pk[k/4], bt[k/4]);
        end
      end else if (k == 0) begin
        n_checks++;
        if ({o_valid, o_busy} !== 2'b01) begin
          n_fails++; $display("FAIL basic_first got v=%0b busy=%0b want v=0 busy=1", o_valid, o_busy);
        end
      end
    end
    tick();
    n_checks++;
    if ({o_valid, o_busy} !== 2'b00) begin
      n_fails++; $display("FAIL basic_idle got v=%0b busy=%0b want 0 0", o_valid, o_busy);
    end
  endtask

  task automatic test_saturation();
    logic signed [31:0] s [4] = '{5, 32'sh80000000, 7, 8};
    for (int k = 0; k < 4; k++) send(s[k]);
    n_checks++;
    if ({o_valid, o_peak, o_bit} !== {1'b1, 32'h7FFF_FFFF, 1'b1}) begin
      n_fails++; $display("FAIL sat_peak got v=%0b peak=%0d bit=%0b want v=1 peak=2147483647 bit=1", o_valid, o_peak, o_bit);
    end
    n_checks++;
    if ({o_valid, o_busy, o_bit, o_peak} !== {exp_valid, exp_busy, exp_bit, exp_peak}) begin
      n_fails++; $display("FAIL sat_model got peak=%0d want peak=%0d", o_peak, exp_peak);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] mask = '0;
    for (int k = 0; k < 12; k++) begin
      send($signed($urandom_range(0, 4000)) - 32'sd2000);
      mask[k] = o_valid;
      n_checks++;
      if ({o_valid, o_busy, o_bit, o_peak} !== {exp_valid, exp_busy, exp_bit, exp_peak}) begin
        n_fails++;
        $display("FAIL b2b_model k=%0d got v=%0b busy=%0b bit=%0b peak=%0d want v=%0b busy=%0b bit=%0b peak=%0d",
                 k, o_valid, o_busy, o_bit, o_peak, exp_valid, exp_busy, exp_bit, exp_peak);
      end
    end
    n_checks++;
    if (mask !== 12'h888) begin
      n_fails++; $display("FAIL b2b_pulses got=%03h want=888", mask);
    end
  endtask

  task automatic test_len_change();
    logic [5:0] mask = '0;
    logic [1:0] mask2 = '0;
    send(11); send(-22);
    write_reg(3'd2, 32'd2);
    for (int k = 0; k < 6; k++) begin
      send($signed($urandom_range(0, 3000)));
      mask[k] = o_valid;
      n_checks++;
      if ({o_valid, o_busy, o_bit, o_peak} !== {exp_valid, exp_busy, exp_bit, exp_peak}) begin
        n_fails++; $display("FAIL len_model k=%0d got v=%0b peak=%0d want v=%0b peak=%0d", k, o_valid, o_peak, exp_valid, exp_peak);
      end
    end
    n_checks++;
    if (mask !== 6'b101010) begin n_fails++; $display("FAIL len_pulses got=%b want=101010", mask); end
    write_reg(3'd2, 32'd0);
    for (int k = 0; k < 2; k++) begin send(77); mask2[k] = o_valid; end
    n_checks++;
    if (mask2 !== 2'b10) begin n_fails++; $display("FAIL len_zero_ignored got=%b want=10", mask2); end
    write_reg(3'd2, 32'd4);
  endtask

  task automatic test_abort();
    logic [3:0] mask = '0;
    send(2500); send(-2600);
    start = 1'b0;
    tick(); tick();
    n_checks++;
    if ({o_valid, o_busy} !== 2'b00) begin n_fails++; $display("FAIL abort_clear got v=%0b busy=%0b want 0 0", o_valid, o_busy); end
    start = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin send(2000); mask[k] = o_valid; end
    n_checks++;
    if ({mask, o_peak} !== {4'b1000, 32'd2000}) begin
      n_fails++; $display("FAIL abort_window got mask=%b peak=%0d want mask=1000 peak=2000", mask, o_peak);
    end
    write_reg(3'd0, 32'd3000);
    write_reg(3'd1, 32'd2500);
    write_reg(3'd2, 32'd2);
    send(5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({o_valid, o_busy, o_bit, o_peak} !== 35'd0) begin
      n_fails++; $display("FAIL rst_mid got v=%0b busy=%0b bit=%0b peak=%0d want all 0", o_valid, o_busy, o_bit, o_peak);
    end
    tick();
    mask = '0;
    for (int k = 0; k < 4; k++) begin send(-2000); mask[k] = o_valid; end
    n_checks++;
    if ({mask, o_peak, o_bit} !== {4'b1000, 32'd2000, 1'b1}) begin
      n_fails++; $display("FAIL rst_defaults got mask=%b peak=%0d bit=%0b want mask=1000 peak=2000 bit=1", mask, o_peak, o_bit);
    end
  endtask

  task automatic test_hysteresis();
    logic signed [31:0] s [16] = '{-30, 12, 0, 7,   3, -10, 9, 1,   30, -29, 2, 0,   20, -50, 49, 0};
    logic [31:0] pk [4] = '{32'd30, 32'd10, 32'd30, 32'd50};
    logic        bt [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    write_reg(3'd0, 32'd50);
    write_reg(3'd1, 32'd20);
    for (int k = 0; k < 16; k++) begin
      send(s[k]);
      if (k % 4 == 3) begin
        n_checks++;
        if ({o_valid, o_peak, o_bit} !== {1'b1, pk[k/4], bt[k/4]}) begin
          n_fails++;
          $display("FAIL hyst w=%0d got v=%0b peak=%0d bit=%0b want v=1 peak=%0d bit=%0b",
                   k/4, o_valid, o_peak, o_bit, pk[k/4], bt[k/4]);
        end
      end
    end
  endtask

  task automatic test_random();
    int pulses = 0;
    for (int c = 0; c < 800; c++) begin
      reset   = ($urandom_range(0, 299) == 0);
      start   = ($urandom_range(0, 15) != 0);
      i_valid = $urandom_range(0, 1);
      case ($urandom_range(0, 7))
        0:       i_signal = 32'sh80000000;
        1:       i_signal = $signed($urandom);
        default: i_signal = $signed($urandom_range(0, 240)) - 32'sd120;
      endcase
      enabel  = ($urandom_range(0, 9) == 0);
      address = 3'($urandom_range(0, 3));
      data    = (address == 3'd2) ? $urandom_range(0, 5) : $urandom_range(0, 130);
      tick();
      if (o_valid) pulses++;
      n_checks++;
      if ({o_valid, o_busy, o_bit, o_peak} !== {exp_valid, exp_busy, exp_bit, exp_peak}) begin
        n_fails++;
        $display("FAIL rand_model c=%0d got v=%0b busy=%0b bit=%0b peak=%0d want v=%0b busy=%0b bit=%0b peak=%0d",
                 c, o_valid, o_busy, o_bit, o_peak, exp_valid, exp_busy, exp_bit, exp_peak);
      end
    end
    reset = 1'b0; enabel = 1'b0; i_valid = 1'b0;
    n_checks++;
    if (pulses == 0) begin n_fails++; $display("FAIL rand_activity got pulses=0 want >0"); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_len_change();
    test_abort();
    test_hysteresis();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
